// File: rtl/instr_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package instr_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Frame layout: header length bytes, bytes per word, trailing checksum bytes
  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CHK_BYTES      = 1;

  // The stream is only accepted while a frame is being parsed
  function automatic logic state_accepts_byte(input state_e s);
    logic acc;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: acc = 1'b1;
      default:                                 acc = 1'b0;
    endcase
    return acc;
  endfunction

  // Total bytes on the wire for a frame announcing len_words words
  function automatic logic [31:0] frame_bytes(input logic [15:0] len_words);
    return 32'(LEN_BYTES) + ({16'd0, len_words} * 32'(BYTES_PER_WORD)) + 32'(CHK_BYTES);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs a byte stream into big-endian 32-bit words and keeps a running XOR.
module loader_word_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_stb_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic [7:0]  xor_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q,   cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  xor_q,   xor_d;

  // The 4th byte completes the word in the same cycle it is strobed in
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_stb_i & ~clear_i & (cnt_q == LAST_BYTE);
  assign xor_o        = xor_q;

  // Next-state for byte counter, shift register and checksum
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    xor_d   = xor_q;
    if (clear_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
      xor_d   = 8'd0;
    end else if (byte_stb_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
      xor_d   = xor_q ^ byte_i;
    end else begin
      cnt_d   = cnt_q;
    end
  end

  // Packer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      xor_q   <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      xor_q   <= xor_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Framed byte-stream program loader: writes words to instruction memory and
// releases the processor reset only after a checksum-verified image.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;

  logic        byte_fire_s;
  logic        data_stb_s;
  logic        pack_clear_s;
  logic [31:0] word_s;
  logic        word_valid_s;
  logic [7:0]  chk_s;
  logic [15:0] len_full_s;

  assign in_ready    = state_accepts_byte(state_q);
  assign byte_fire_s = in_valid & in_ready;
  assign data_stb_s  = byte_fire_s & (state_q == ST_DATA);
  assign len_full_s  = {len_q[15:8], in_data};

  loader_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pack_clear_s),
    .byte_stb_i   (data_stb_s),
    .byte_i       (in_data),
    .word_o       (word_s),
    .word_valid_o (word_valid_s),
    .xor_o        (chk_s)
  );

  // FSM next-state, write generation and status decode
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pack_clear_s = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_LEN_HI;
          word_idx_d   = 16'd0;
          pack_clear_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (byte_fire_s) begin
          len_d   = {in_data, len_q[7:0]};
          state_d = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (byte_fire_s) begin
          len_d = len_full_s;
          if ((len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_WORDS_W)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        if (word_valid_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
          mem_wdata_d = word_s;
          word_idx_d  = word_idx_q + 16'd1;
          if (word_idx_q == (len_q - 16'd1)) begin
            state_d = ST_CHECK;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_CHECK: begin
        if (byte_fire_s) begin
          state_d = (in_data == chk_s) ? ST_DONE : ST_ERR;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status follows the state being entered so it is valid one cycle later
    done_d      = (state_d == ST_DONE);
    cpu_rst_n_d = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERR);
  end

  // State and output registers; reset also cancels any pending write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 16'd0;
      word_idx_q  <= 16'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; a second instance with BASE_ADDR=0x100
// shares the stimulus so relocated addresses can be checked.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;

  logic        in_ready0, mem_we0, cpu_rst_n0, done0, error0;
  logic [31:0] mem_addr0, mem_wdata0;
  logic        in_ready1, mem_we1, cpu_rst_n1, done1, error1;
  logic [31:0] mem_addr1, mem_wdata1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  logic [7:0]  frame_q[$];

  instr_mem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_rst_n(cpu_rst_n0), .done(done0), .error(error0)
  );

  instr_mem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_rst_n(cpu_rst_n1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  // Log every write strobe seen at the falling edge
  always @(negedge clk) begin
    if (mem_we0) begin
      wa0.push_back(mem_addr0);
      wd0.push_back(mem_wdata0);
    end
    if (mem_we1) begin
      wa1.push_back(mem_addr1);
      wd1.push_back(mem_wdata1);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte until it is accepted (bounded), then idle for gap cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 32; t++) begin
      @(negedge clk);
      if (in_ready0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check_eq("byte_accept_timeout", {31'd0, in_ready0}, 32'd1);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], gap);
  endtask

  task automatic load_good_frame(input logic [7:0] chk);
    frame_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    frame_q.push_back(chk);
  endtask

  task automatic check_two_writes(input string tag);
    check_eq({tag, "_nwr"}, 32'(wa0.size()), 32'd2);
    if (wa0.size() >= 2) begin
      check_eq({tag, "_a0"}, wa0[0], 32'h0000_0000);
      check_eq({tag, "_d0"}, wd0[0], 32'hDEAD_BEEF);
      check_eq({tag, "_a1"}, wa0[1], 32'h0000_0004);
      check_eq({tag, "_d1"}, wd0[1], 32'h1234_5678);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic cr);
    check_eq({tag, "_done"},  {31'd0, done0},      {31'd0, d});
    check_eq({tag, "_error"}, {31'd0, error0},     {31'd0, e});
    check_eq({tag, "_cpurn"}, {31'd0, cpu_rst_n0}, {31'd0, cr});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;

    // 1. Reset with a byte offered: nothing accepted, all outputs idle
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {31'd0, in_ready0}, 32'd0);
    check_eq("rst_we",    {31'd0, mem_we0},   32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", {31'd0, in_ready0}, 32'd0);
    check_eq("idle_addr",  mem_addr0,  32'd0);
    check_eq("idle_wdata", mem_wdata0, 32'd0);
    @(posedge clk); #1;

    // 2. Good load
    clear_logs();
    pulse_start();
    load_good_frame(8'h2A);
    send_frame(0);
    check_status("good", 1'b1, 1'b0, 1'b1);
    check_two_writes("good");
    check_eq("good_hold_addr",  mem_addr0,  32'h0000_0004);
    check_eq("good_hold_wdata", mem_wdata0, 32'h1234_5678);

    // 3. Reload from DONE with a bad checksum, then recover
    clear_logs();
    pulse_start();
    check_status("reload", 1'b0, 1'b0, 1'b0);
    load_good_frame(8'h2B);
    send_frame(0);
    check_status("badchk", 1'b0, 1'b1, 1'b0);
    check_two_writes("badchk");
    clear_logs();
    pulse_start();
    check_eq("err_clear", {31'd0, error0}, 32'd0);
    load_good_frame(8'h2A);
    send_frame(0);
    check_status("recover", 1'b1, 1'b0, 1'b1);
    check_two_writes("recover");

    // 4. Header length errors and the largest accepted length
    clear_logs();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_status("len0", 1'b0, 1'b1, 1'b0);
    check_eq("len0_ready", {31'd0, in_ready0}, 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_status("len257", 1'b0, 1'b1, 1'b0);
    check_eq("lenerr_nwr", 32'(wa0.size()), 32'd0);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    check_eq("len256_error", {31'd0, error0},    32'd0);
    check_eq("len256_ready", {31'd0, in_ready0}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 5. Byte offered in IDLE is refused; gapped stream loads identically
    in_valid = 1'b1; in_data = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("idle_byte_ready", {31'd0, in_ready0}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clear_logs();
    pulse_start();
    load_good_frame(8'h2A);
    send_frame(1);
    check_status("gapped", 1'b1, 1'b0, 1'b1);
    check_two_writes("gapped");

    // 6. Reset right after a word completes, then relocated reload
    pulse_start();
    frame_q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (4) @(posedge clk);
    #1;
    check_eq("midrst_nwr",   32'(wa0.size()), 32'd0);
    check_eq("midrst_ready", {31'd0, in_ready0}, 32'd0);
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    pulse_start();
    load_good_frame(8'h2A);
    send_frame(0);
    check_eq("reloc_done",  {31'd0, done1},      32'd1);
    check_eq("reloc_cpurn", {31'd0, cpu_rst_n1}, 32'd1);
    check_eq("reloc_nwr",   32'(wa1.size()), 32'd2);
    if (wa1.size() >= 2) begin
      check_eq("reloc_a0", wa1[0], 32'h0000_0100);
      check_eq("reloc_d0", wd1[0], 32'hDEAD_BEEF);
      check_eq("reloc_a1", wa1[1], 32'h0000_0104);
      check_eq("reloc_d1", wd1[1], 32'h1234_5678);
    end
    check_two_writes("base0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Byte-stream program loader, the writer side of the processor's instruction-memory read port. It receives a framed program image over a valid/ready byte interface. It packs the bytes into 32-bit big-endian words and writes them sequentially into instruction memory. It holds the processor in reset (cpu_rst_n low) until a complete, checksum-verified image has been written.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written
MAX_WORDS, 256, largest word count accepted in a frame header (1..65535)

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction-memory write strobe, one cycle per word
mem_addr  output  32  byte address of the word being written
mem_wdata  output  32  word being written
cpu_rst_n  output  1  active-low reset to the processor core
done  output  1  image loaded and verified
error  output  1  frame rejected

Behaviour:
- Reset: clk and rst only; rst is sampled on the rising edge of clk. It has priority over all other inputs.
- After a cycle with rst=1, the block is in state IDLE. mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, cpu_rst_n=0, in_ready=0. All counters and the checksum are 0.
- Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, then 1 checksum byte. The checksum is the XOR of all data bytes only; the length bytes are excluded.
- Handshake: a byte is consumed on any edge where in_valid=1 and in_ready=1. in_ready is a combinational decode of state: it is 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 elsewhere. Bytes presented while in_ready=0 are left unconsumed. Gaps in in_valid of any length are legal.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- IDLE: on start, go to LEN_HI. Clear the word index, byte counter and checksum.
- LEN_HI: on a consumed byte, latch len[15:8] and go to LEN_LO.
- LEN_LO: on a consumed byte, latch len[7:0]. If len==0 or len>MAX_WORDS, go to ERR; otherwise go to DATA.
- DATA: each consumed byte is XORed into the checksum and shifted into the word register; the first byte of a word lands in [31:24].
  - On the 4th byte of a word, mem_we=1 on the next cycle for exactly one cycle, with mem_addr = BASE_ADDR + 4*word_idx (mod 2^32) and mem_wdata = the assembled word. word_idx then increments.
  - When the consumed byte completes word N-1, go to CHECK. The final write strobe still fires on the first CHECK cycle.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- CHECK: on a consumed byte, go to DONE if it equals the checksum, otherwise go to ERR.
- DONE: done=1 and cpu_rst_n=1, both registered and asserted on the cycle after the checksum byte is consumed. On start: done=0, cpu_rst_n=0, go to LEN_HI (reload).
- ERR: error=1 and cpu_rst_n=0. On start: error=0, go to LEN_HI. Words already written are not rolled back.
- start is ignored in LEN_HI, LEN_LO, DATA and CHECK.
- Reset mid-load: return to IDLE. No mem_we is issued after the reset edge, including a write pending from a just-completed word.
- Widths: word_idx and len are 16 bits. The address is computed as BASE_ADDR + {word_idx,2'b00} in 32 bits.

Decomposition:
- Shared package instr_loader_pkg holds:
  - the FSM state typedef (3-bit encoding)
  - frame constants: LEN_BYTES=2, BYTES_PER_WORD=4, CHK_BYTES=1
- One sub-module, loader_word_packer, handles byte-to-word assembly:
  - inputs: byte, byte strobe, clear
  - outputs: 32-bit word, word_valid pulse, running XOR
- The FSM, address generation and processor reset control stay in instr_mem_loader.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1 -> in_ready=0, mem_we=0, done=0, error=0, cpu_rst_n=0, and no byte is consumed.
2. Good load: start, then bytes 00 02 DE AD BE EF 12 34 56 78 2A -> writes (0x0, DEADBEEF) and (0x4, 12345678), each as a one-cycle mem_we. One cycle after the checksum byte is consumed, done=1 and cpu_rst_n=1.
3. Bad checksum: the same frame with checksum 2B -> both writes occur, then error=1, done=0, cpu_rst_n=0. A subsequent start followed by the good frame -> done=1.
4. Length errors: header 00 00 -> ERR after LEN_LO with no mem_we. Header 01 01 with MAX_WORDS=256 -> ERR with no mem_we.
5. Flow control: the good frame with in_valid toggling every other cycle, plus a byte presented in IDLE before start -> identical writes and result to scenario 2. The IDLE byte is not consumed (in_ready=0).
6. Reset mid-load: rst=1 on the cycle after the 4th data byte is consumed -> no mem_we appears, state is IDLE. A restarted good load with BASE_ADDR=32'h100 writes to 0x100 and 0x104 and reaches done=1.
